// File: rtl/shift_reg_param.sv
// shift_reg_param: WIDTH x DEPTH multi-mode shift register with
// forward/backward shift, rotate, parallel load, clear and fill tracking.
module shift_reg_param #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     rot,
    input  logic [WIDTH-1:0]         d,
    input  logic [WIDTH*DEPTH-1:0]   load_data,
    output logic [WIDTH-1:0]         q_fwd,
    output logic [WIDTH-1:0]         q_bwd,
    output logic [WIDTH*DEPTH-1:0]   taps,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                     full
);

    localparam int FW = $clog2(DEPTH+1);
    localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_FWD  = 2'b01,
        MODE_BWD  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;
    logic [FW-1:0]               fill_q;
    logic [FW-1:0]               fill_d;
    logic [FW-1:0]               fill_inc;
    logic                        full_q;
    logic [WIDTH-1:0]            fwd_in;
    logic [WIDTH-1:0]            bwd_in;

    assign fwd_in   = rot ? stage_q[DEPTH-1] : d;
    assign bwd_in   = rot ? stage_q[0] : d;
    // rotation recirculates existing data, so only serial inputs count
    assign fill_inc = (rot || fill_q == FULL_CNT) ? fill_q : fill_q + FW'(1);

    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (clr) begin
            stage_d = {DEPTH{RESET_VAL}};
            fill_d  = '0;
        end else if (en) begin
            unique case (mode_e'(mode))
                MODE_HOLD: ;
                MODE_FWD: begin
                    stage_d = {stage_q[DEPTH-2:0], fwd_in};
                    fill_d  = fill_inc;
                end
                MODE_BWD: begin
                    stage_d = {bwd_in, stage_q[DEPTH-1:1]};
                    fill_d  = fill_inc;
                end
                MODE_LOAD: begin
                    stage_d = load_data;
                    fill_d  = FULL_CNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q <= {DEPTH{RESET_VAL}};
            fill_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
            full_q  <= (fill_d == FULL_CNT);
        end
    end

    assign taps  = stage_q;
    assign q_fwd = stage_q[DEPTH-1];
    assign q_bwd = stage_q[0];
    assign fill  = fill_q;
    assign full  = full_q;

endmodule

// File: tb/tb_shift_reg_param.sv
// tb_shift_reg_param: directed vectors for the default shift register
// and two parameter variants sharing one control bus.
module tb_shift_reg_param;

    logic clk = 1'b0;
    logic rstn, clr, en, rot;
    logic [1:0] mode;

    logic [7:0]   d0;
    logic [31:0]  ld0;
    logic [7:0]   qf0, qb0;
    logic [31:0]  taps0;
    logic [2:0]   fill0;
    logic         full0;

    logic         d1;
    logic [1:0]   ld1;
    logic         qf1, qb1;
    logic [1:0]   taps1;
    logic [1:0]   fill1;
    logic         full1;

    logic [15:0]  d2;
    logic [127:0] ld2;
    logic [15:0]  qf2, qb2;
    logic [127:0] taps2;
    logic [3:0]   fill2;
    logic         full2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_reg_param #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u0 (
        .clk(clk), .rstn(rstn), .clr(clr), .en(en), .mode(mode),
        .rot(rot), .d(d0), .load_data(ld0), .q_fwd(qf0), .q_bwd(qb0),
        .taps(taps0), .fill(fill0), .full(full0)
    );

    shift_reg_param #(.WIDTH(1), .DEPTH(2), .RESET_VAL(1'b0)) u1 (
        .clk(clk), .rstn(rstn), .clr(clr), .en(en), .mode(mode),
        .rot(rot), .d(d1), .load_data(ld1), .q_fwd(qf1), .q_bwd(qb1),
        .taps(taps1), .fill(fill1), .full(full1)
    );

    shift_reg_param #(.WIDTH(16), .DEPTH(8), .RESET_VAL(16'hFFFF)) u2 (
        .clk(clk), .rstn(rstn), .clr(clr), .en(en), .mode(mode),
        .rot(rot), .d(d2), .load_data(ld2), .q_fwd(qf2), .q_bwd(qb2),
        .taps(taps2), .fill(fill2), .full(full2)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs,
                            input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [31:0] t,
                        input logic [2:0] f, input logic fl);
        check_eq({tag, ".taps"}, 128'(taps0), 128'(t));
        check_eq({tag, ".fill"}, 128'(fill0), 128'(f));
        check_eq({tag, ".full"}, 128'(full0), 128'(fl));
    endtask

    task automatic fwd0(input logic [7:0] v);
        en = 1'b1; mode = 2'b01; rot = 1'b0; d0 = v;
        tick();
    endtask

    initial begin
        logic [7:0] seq [4];
        seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        rstn = 1'b0; clr = 1'b0; en = 1'b0; mode = 2'b00; rot = 1'b0;
        d0 = '0; ld0 = '0; d1 = '0; ld1 = '0; d2 = '0; ld2 = '0;
        #12;
        chk0("reset", 32'h0, 3'd0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1;

        for (int i = 0; i < 4; i++) begin
            fwd0(seq[i]);
            if (i == 2) chk0("fill3", 32'h00A1B2C3, 3'd3, 1'b0);
        end
        chk0("fwd4", 32'hA1B2C3D4, 3'd4, 1'b1);
        check_eq("fwd4.q_fwd", 128'(qf0), 128'(8'hA1));
        check_eq("fwd4.q_bwd", 128'(qb0), 128'(8'hD4));
        fwd0(8'hE5);
        chk0("sat", 32'hB2C3D4E5, 3'd4, 1'b1);

        mode = 2'b11; ld0 = 32'h11223344; d0 = 8'hEE; rot = 1'b1;
        tick();
        chk0("load", 32'h11223344, 3'd4, 1'b1);
        check_eq("load.q_fwd", 128'(qf0), 128'(8'h11));
        check_eq("load.q_bwd", 128'(qb0), 128'(8'h44));
        mode = 2'b01; rot = 1'b1;
        tick();
        chk0("rotf", 32'h22334411, 3'd4, 1'b1);
        mode = 2'b10;
        tick();
        tick();
        chk0("rotb2", 32'h44112233, 3'd4, 1'b1);

        mode = 2'b11; rot = 1'b0;
        tick();
        mode = 2'b10; d0 = 8'h55;
        tick();
        chk0("bwd", 32'h55112233, 3'd4, 1'b1);
        check_eq("bwd.q_bwd", 128'(qb0), 128'(8'h33));

        clr = 1'b1; en = 1'b1; mode = 2'b01; d0 = 8'hAA;
        tick();
        clr = 1'b0;
        chk0("clr", 32'h0, 3'd0, 1'b0);
        fwd0(8'h5A);
        chk0("fwd1", 32'h0000005A, 3'd1, 1'b0);
        en = 1'b0; mode = 2'b11; ld0 = 32'hDEADBEEF;
        tick();
        chk0("en0", 32'h0000005A, 3'd1, 1'b0);
        en = 1'b1; mode = 2'b00; d0 = 8'h99;
        tick();
        chk0("hold", 32'h0000005A, 3'd1, 1'b0);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) fwd0(seq[i]);
        chk0("refill", 32'hA1B2C3D4, 3'd4, 1'b1);
        #3;
        rstn = 1'b0;
        #1;
        chk0("async", 32'h0, 3'd0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        fwd0(8'h77);
        chk0("post_rst", 32'h00000077, 3'd1, 1'b0);

        #2;
        rstn = 1'b0;
        #1;
        check_eq("u1.rst", 128'(taps1), 128'(2'b00));
        check_eq("u2.rst", taps2, {8{16'hFFFF}});
        check_eq("u2.rst_fill", 128'(fill2), 128'(4'd0));
        @(negedge clk);
        rstn = 1'b1;
        #1;
        en = 1'b1; mode = 2'b01; rot = 1'b0; d1 = 1'b1; d2 = 16'h0101;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("u1.clr", 128'(taps1), 128'(2'b00));
        check_eq("u2.clr", taps2, {8{16'hFFFF}});
        check_eq("u2.clr_fill", 128'(fill2), 128'(4'd0));

        for (int k = 1; k <= 8; k++) begin
            d1 = (k == 1);
            d2 = (k == 1) ? 16'h1234 : 16'h0000;
            tick();
            if (k <= 2) begin
                check_eq($sformatf("u1.lat%0d", k), 128'(qf1), 128'(k == 2));
                check_eq($sformatf("u1.full%0d", k), 128'(full1), 128'(k == 2));
            end
            check_eq($sformatf("u2.lat%0d", k), 128'(qf2),
                     128'((k == 8) ? 16'h1234 : 16'hFFFF));
            check_eq($sformatf("u2.full%0d", k), 128'(full2), 128'(k == 8));
            check_eq($sformatf("u2.fill%0d", k), 128'(fill2), 128'(k));
        end

        clr = 1'b1;
        tick();
        clr = 1'b0; mode = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            d2 = (k == 1) ? 16'hABCD : 16'h0000;
            tick();
            check_eq($sformatf("u2.blat%0d", k), 128'(qb2),
                     128'((k == 8) ? 16'hABCD : 16'hFFFF));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
